banco_de_registros: RTL and testbench
=====================================

// Module: banco_de_registros
// PURPOSE
//  8088-style general register file: AX, BX, CX, DX, SP, BP, SI, DI, each 16 bits.
//  - Single bidirectional 16-bit data bus.
//  - Byte access to the high/low halves of AX..DX.
//  - Sits between the execution unit's internal data bus and the ALU/address logic.
//  - Writes are clocked; reads are combinational onto the shared bus.
// PARAMETERS
//  none (width 16 and depth 8 are architectural constants, taken from the package)
// PORTS
//  clk                in     1   system clock; all state updates on its rising edge
//  reset              in     1   asynchronous, active-high; clears every register
//  select_reg         in     3   register index: 0 AX, 1 BX, 2 CX, 3 DX, 4 SP, 5 BP, 6 SI, 7 DI
//  size               in     1   1 = 16-bit word access, 0 = 8-bit byte access
//  select_high_low    in     1   byte access only: 0 = low half (xL), 1 = high half (xH)
//  select_data_h_reg  in     1   byte access only: bus byte lane used, 0 = data[7:0], 1 = data[15:8]
//  read_write         in     1   1 = write (bus is input), 0 = read (block drives bus)
//  data               inout  16  shared data bus
// BEHAVIOUR
//  Reset
//  - While reset=1, all eight registers are forced to 16'h0000 asynchronously.
//  - Writes are blocked while reset=1.
//  - Bus direction still follows read_write, so a read during reset returns 16'h0000.
//  Write (read_write=1)
//  - Block tri-states data (16'hzzzz) and samples it on the rising edge of clk.
//  - size=1: reg[select_reg] <= data.
//  - size=0, select_reg 0..3: the byte lane selected by select_data_h_reg is written
//    into the half selected by select_high_low; the other half is unchanged.
//  - size=0, select_reg 4..7: no byte halves exist; the write is ignored and the
//    register keeps its value.
//  Read (read_write=0)
//  - Purely combinational, zero latency; data follows select/size changes in the same delta.
//  - size=1: data = reg[select_reg].
//  - size=0, select_reg 0..3: the chosen half is placed on the lane given by
//    select_data_h_reg; the other lane is 8'h00.
//  - size=0, select_reg 4..7: full 16-bit register value.
//  Timing and boundary cases
//  - Write on edge N is visible on a read issued immediately after edge N.
//  - Back-to-back writes to the same or different registers every cycle are legal.
//  - No stalls, no handshake.
//  - X/Z on data during a write is stored as-is; no checking.
//  - reset asserted mid-write aborts that write: register = 0, never a partial byte.
// STRUCTURE
//  Package banco_regs_pkg
//  - localparams REG_AX=3'd0 .. REG_DI=3'd7, DATA_W=16, NUM_REGS=8.
//  - typedef logic [15:0] word_t.
//  Sub-module
//  - One natural leaf, reg16_byte_en: a 16-bit register with async reset and
//    separate hi/lo byte enables.
//  - Instantiated 8x.
//  - Top holds the write-enable decode, write-data lane steering, read mux and
//    tri-state driver.
// TESTING
//  Bench must drive data through its own tri-state buffer (release to 'z when
//  read_write=0) to avoid bus contention.
//  1. reset=1 20ns, then read AX..DI -> every read returns 16'h0000.
//  2. Write AX=16'hABCD (size=1), then read AX -> 16'hABCD.
//  3. Byte writes, then word read:
//     - BL: size=0, hl=0, lane=0, data=16'h00EF.
//     - BH: hl=1, lane=0, data=16'h0012.
//     - read BX size=1 -> 16'h12EF.
//     - byte read BH with lane=1 -> 16'h1200.
//  4. Word writes CX=3456, DX=789A, SP=FFFC, BP=AABB, SI=CCDD, DI=EEFF; read back
//     in order SP, DI, BP, SI, CX, DX -> exact values, other registers untouched.
//  5. Ignored byte write: size=0 write to SP (select_reg=4) with data=16'h1111
//     -> SP still FFFC.
//  6. Assert reset asynchronously mid-cycle after test 4 -> all reads 16'h0000
//     before the next clk edge.

Source files
------------

// File: rtl/banco_de_registros_pkg.sv
// Shared constants and types for the 8088-style general register file.
package banco_regs_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  localparam logic [2:0] REG_AX = 3'd0;
  localparam logic [2:0] REG_BX = 3'd1;
  localparam logic [2:0] REG_CX = 3'd2;
  localparam logic [2:0] REG_DX = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  localparam logic [2:0] REG_SI = 3'd6;
  localparam logic [2:0] REG_DI = 3'd7;

  typedef logic [15:0] word_t;

  // Only AX..DX expose addressable xH/xL halves.
  function automatic logic has_byte_halves(input logic [2:0] sel);
    return (sel <= REG_DX);
  endfunction

endpackage

// File: rtl/banco_de_registros_reg16_byte_en.sv
// 16-bit storage register with asynchronous clear and independent byte enables.
module reg16_byte_en
  import banco_regs_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hi_en,
  input  logic  lo_en,
  input  word_t d,
  output word_t q
);

  word_t q_r;

  // Byte-granular storage; reset wins over any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 16'h0000;
    end else begin
      if (hi_en) begin
        q_r[15:8] <= d[15:8];
      end
      if (lo_en) begin
        q_r[7:0] <= d[7:0];
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/banco_de_registros.sv
// General register file AX..DI on a single bidirectional bus with byte access to AX..DX.
module banco_de_registros
  import banco_regs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  select_reg,
  input  logic        size,
  input  logic        select_high_low,
  input  logic        select_data_h_reg,
  input  logic        read_write,
  inout  wire  [15:0] data
);

  word_t               q_s [NUM_REGS];
  logic [NUM_REGS-1:0] hi_en_s;
  logic [NUM_REGS-1:0] lo_en_s;
  logic [7:0]          wr_byte_s;
  word_t               wr_data_s;
  word_t               sel_q_s;
  logic [7:0]          rd_byte_s;
  word_t               rd_data_s;

  // Write-enable decode: word writes hit both halves, byte writes only one half of AX..DX.
  always_comb begin
    hi_en_s = {NUM_REGS{1'b0}};
    lo_en_s = {NUM_REGS{1'b0}};
    if (read_write && !reset) begin
      if (size) begin
        hi_en_s[select_reg] = 1'b1;
        lo_en_s[select_reg] = 1'b1;
      end else if (has_byte_halves(select_reg)) begin
        if (select_high_low) begin
          hi_en_s[select_reg] = 1'b1;
        end else begin
          lo_en_s[select_reg] = 1'b1;
        end
      end else begin
        hi_en_s = {NUM_REGS{1'b0}};
      end
    end else begin
      lo_en_s = {NUM_REGS{1'b0}};
    end
  end

  // Byte writes replicate the chosen bus lane so either half can take it.
  always_comb begin
    wr_byte_s = select_data_h_reg ? data[15:8] : data[7:0];
    if (size) begin
      wr_data_s = data;
    end else begin
      wr_data_s = {wr_byte_s, wr_byte_s};
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg16_byte_en u_reg (
      .clk   (clk),
      .rst   (reset),
      .hi_en (hi_en_s[g]),
      .lo_en (lo_en_s[g]),
      .d     (wr_data_s),
      .q     (q_s[g])
    );
  end

  // Read mux: byte reads of AX..DX land on one lane with the other lane zeroed.
  always_comb begin
    sel_q_s   = q_s[select_reg];
    rd_byte_s = select_high_low ? sel_q_s[15:8] : sel_q_s[7:0];
    if (size || !has_byte_halves(select_reg)) begin
      rd_data_s = sel_q_s;
    end else if (select_data_h_reg) begin
      rd_data_s = {rd_byte_s, 8'h00};
    end else begin
      rd_data_s = {8'h00, rd_byte_s};
    end
  end

  assign data = read_write ? 16'hzzzz : rd_data_s;

endmodule

// File: tb/tb_banco_de_registros.sv
// Self-checking bench: directed vector table, async-reset corner cases, randomized ops vs. model.
module tb_banco_de_registros;
  import banco_regs_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  select_reg;
  logic        size;
  logic        select_high_low;
  logic        select_data_h_reg;
  logic        read_write;
  logic [15:0] tb_wdata;
  wire  [15:0] data_w;

  int tests;
  int failed;

  assign data_w = read_write ? tb_wdata : 16'hzzzz;

  banco_de_registros dut (
    .clk               (clk),
    .reset             (reset),
    .select_reg        (select_reg),
    .size              (size),
    .select_high_low   (select_high_low),
    .select_data_h_reg (select_data_h_reg),
    .read_write        (read_write),
    .data              (data_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  sel;
    logic        sz;
    logic        hl;
    logic        lane;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] model [8];

  function automatic vec_t wr(input logic [2:0] sel, input logic sz, input logic hl,
                              input logic lane, input logic [15:0] d);
    vec_t v;
    v = '{1'b1, sel, sz, hl, lane, d, 16'h0000, "write"};
    return v;
  endfunction

  function automatic vec_t rd(input logic [2:0] sel, input logic sz, input logic hl,
                              input logic lane, input logic [15:0] e, input string n);
    vec_t v;
    v = '{1'b0, sel, sz, hl, lane, 16'h0000, e, n};
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [2:0] sel, input logic sz,
                       input logic hl, input logic lane, input logic [15:0] d);
    read_write        = rw;
    select_reg        = sel;
    size              = sz;
    select_high_low   = hl;
    select_data_h_reg = lane;
    tb_wdata          = d;
  endtask

  // Each op starts at a falling edge; reads are sampled 2ns later, writes commit on the next rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v.rw, v.sel, v.sz, v.hl, v.lane, v.wdata);
    if (v.rw) begin
      @(posedge clk);
    end else begin
      #2;
      check(v.name, data_w, v.exp);
    end
  endtask

  function automatic void model_write(input logic [2:0] sel, input logic sz, input logic hl,
                                      input logic lane, input logic [15:0] d);
    logic [15:0] b;
    b = lane ? (d >> 8) : (d & 16'h00FF);
    if (sz) begin
      model[sel] = d;
    end else if (sel < 3'd4) begin
      if (hl) model[sel] = (model[sel] & 16'h00FF) | (b << 8);
      else    model[sel] = (model[sel] & 16'hFF00) | b;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] sel, input logic sz,
                                             input logic hl, input logic lane);
    logic [15:0] v;
    if (sz || sel >= 3'd4) return model[sel];
    v = hl ? (model[sel] >> 8) : (model[sel] & 16'h00FF);
    return lane ? (v << 8) : v;
  endfunction

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    drive(1'b0, REG_AX, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Read while reset is held must already return zero.
    #3;
    check("read_during_reset", data_w, 16'h0000);
    #17;
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 8; r++) vecs.push_back(rd(3'(r), 1'b1, 1'b0, 1'b0, 16'h0000, "reset_val"));
    vecs.push_back(wr(REG_AX, 1'b1, 1'b0, 1'b0, 16'hABCD));
    vecs.push_back(rd(REG_AX, 1'b1, 1'b0, 1'b0, 16'hABCD, "word_ax"));
    vecs.push_back(wr(REG_BX, 1'b0, 1'b0, 1'b0, 16'h00EF));
    vecs.push_back(wr(REG_BX, 1'b0, 1'b1, 1'b0, 16'h0012));
    vecs.push_back(rd(REG_BX, 1'b1, 1'b0, 1'b0, 16'h12EF, "bx_word"));
    vecs.push_back(rd(REG_BX, 1'b0, 1'b1, 1'b1, 16'h1200, "bh_lane1"));
    vecs.push_back(rd(REG_BX, 1'b0, 1'b0, 1'b0, 16'h00EF, "bl_lane0"));
    vecs.push_back(wr(REG_CX, 1'b1, 1'b0, 1'b0, 16'h3456));
    vecs.push_back(wr(REG_DX, 1'b1, 1'b0, 1'b0, 16'h789A));
    vecs.push_back(wr(REG_SP, 1'b1, 1'b0, 1'b0, 16'hFFFC));
    vecs.push_back(wr(REG_BP, 1'b1, 1'b0, 1'b0, 16'hAABB));
    vecs.push_back(wr(REG_SI, 1'b1, 1'b0, 1'b0, 16'hCCDD));
    vecs.push_back(wr(REG_DI, 1'b1, 1'b0, 1'b0, 16'hEEFF));
    vecs.push_back(rd(REG_SP, 1'b1, 1'b0, 1'b0, 16'hFFFC, "sp"));
    vecs.push_back(rd(REG_DI, 1'b1, 1'b0, 1'b0, 16'hEEFF, "di"));
    vecs.push_back(rd(REG_BP, 1'b1, 1'b0, 1'b0, 16'hAABB, "bp"));
    vecs.push_back(rd(REG_SI, 1'b1, 1'b0, 1'b0, 16'hCCDD, "si"));
    vecs.push_back(rd(REG_CX, 1'b1, 1'b0, 1'b0, 16'h3456, "cx"));
    vecs.push_back(rd(REG_DX, 1'b1, 1'b0, 1'b0, 16'h789A, "dx"));
    vecs.push_back(rd(REG_AX, 1'b1, 1'b0, 1'b0, 16'hABCD, "ax_untouched"));
    vecs.push_back(rd(REG_BX, 1'b1, 1'b0, 1'b0, 16'h12EF, "bx_untouched"));
    vecs.push_back(wr(REG_SP, 1'b0, 1'b0, 1'b0, 16'h1111));
    vecs.push_back(rd(REG_SP, 1'b1, 1'b0, 1'b0, 16'hFFFC, "sp_byte_ignored"));
    vecs.push_back(rd(REG_SI, 1'b0, 1'b1, 1'b1, 16'hCCDD, "si_byte_read_full"));
    vecs.push_back(wr(REG_DX, 1'b0, 1'b0, 1'b1, 16'h5500));
    vecs.push_back(rd(REG_DX, 1'b1, 1'b0, 1'b0, 16'h7855, "dl_from_hi_lane"));

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-cycle: reads must drop to zero before the next rising edge.
    @(negedge clk);
    drive(1'b0, REG_SP, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    check("sp_before_async_rst", data_w, 16'hFFFC);
    reset = 1'b1;
    #1;
    check("sp_async_rst", data_w, 16'h0000);
    select_reg = REG_DI;
    #1;
    check("di_async_rst", data_w, 16'h0000);
    select_reg = REG_AX;
    #1;
    check("ax_async_rst", data_w, 16'h0000);

    // Reset asserted during a write aborts it completely.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, REG_AX, 1'b1, 1'b0, 1'b0, 16'h5A5A);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, REG_AX, 1'b0, 1'b1, 1'b0, 16'h00FF);
    #2;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, REG_AX, 1'b1, 1'b0, 1'b0, 16'h0000);
    #2;
    check("write_aborted_by_rst", data_w, 16'h0000);

    // Randomized traffic against the behavioural model.
    for (int r = 0; r < 8; r++) model[r] = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v.rw    = 1'($urandom_range(0, 1));
      v.sel   = 3'($urandom_range(0, 7));
      v.sz    = 1'($urandom_range(0, 1));
      v.hl    = 1'($urandom_range(0, 1));
      v.lane  = 1'($urandom_range(0, 1));
      v.wdata = 16'($urandom);
      v.name  = "random_read";
      if (v.rw) begin
        model_write(v.sel, v.sz, v.hl, v.lane, v.wdata);
        v.exp = 16'h0000;
      end else begin
        v.exp = model_read(v.sel, v.sz, v.hl, v.lane);
      end
      apply(v);
    end
    for (int r = 0; r < 8; r++) begin
      vec_t v;
      v = rd(3'(r), 1'b1, 1'b0, 1'b0, model[r], "random_final");
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
